// File: rtl/bpi_cmd_executor.sv
// rtl/bpi_cmd_executor.sv - BPI sequencer command executor; optional elapsed timer under BPI_TIMER_EN
module bpi_cmd_executor #(
  parameter int          WE_CYC       = 3,
  parameter int          RD_CYC       = 4,
  parameter logic [22:0] CFG_REG_ADDR = 23'h00_F94F
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  command,
  input  logic [22:0] addr_in,
  input  logic [10:0] n_words,
  input  logic [15:0] wr_data,
  input  logic        wr_empty,
  output logic        wr_rden,
  output logic [15:0] rd_data,
  output logic        rd_we,
  output logic        seq_done,
  output logic        busy,
  output logic        cmd_err,
  output logic [31:0] timer,
  output logic [22:0] flash_a,
  output logic [15:0] flash_dq_o,
  input  logic [15:0] flash_dq_i,
  output logic        flash_dq_oe,
  output logic        flash_ce_b,
  output logic        flash_oe_b,
  output logic        flash_we_b,
  output logic        flash_adv_b
);

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_SETUP, S_STROBE, S_HOLD, S_RECOV, S_NEXT, S_DONE, S_WAIT_NOOP
  } state_t;

  localparam logic [1:0] DK_NONE = 2'd0;
  localparam logic [1:0] DK_WR   = 2'd1;
  localparam logic [1:0] DK_RD   = 2'd2;

  state_t      state, state_n;
  logic [4:0]  cmd_q;
  logic [22:0] base, wa;
  logic [1:0]  ncmd, cidx, dk;
  logic [7:0]  c0, c1;
  logic        use_cfg;
  logic [10:0] wcnt;
  logic [7:0]  cnt;

  // decoded cycle list for the latched code
  logic [1:0]  d_ncmd, d_dk;
  logic [7:0]  d_c0, d_c1;
  logic        d_cfg;
  logic [10:0] d_wn, wmax;

  assign wmax = (n_words == 11'd0) ? 11'd1 : n_words;

  // Expand the latched code into command words plus an optional data/read run
  always_comb begin
    d_ncmd = 2'd0; d_c0 = 8'h00; d_c1 = 8'h00; d_cfg = 1'b0; d_dk = DK_NONE; d_wn = 11'd1;
    case (cmd_q)
      5'h01: d_dk = DK_WR;
      5'h02: d_dk = DK_RD;
      5'h03: begin d_dk = DK_WR; d_wn = wmax; end
      5'h04: begin d_dk = DK_RD; d_wn = wmax; end
      5'h05: begin d_ncmd = 2'd1; d_c0 = 8'hFF; end
      5'h06: begin d_ncmd = 2'd1; d_c0 = 8'h70; end
      5'h07: begin d_ncmd = 2'd1; d_c0 = 8'h90; end
      5'h08: begin d_ncmd = 2'd1; d_c0 = 8'h98; end
      5'h09: begin d_ncmd = 2'd1; d_c0 = 8'h50; end
      5'h0A: begin d_ncmd = 2'd2; d_c0 = 8'h20; d_c1 = 8'hD0; end
      5'h0B: begin d_ncmd = 2'd1; d_c0 = 8'h40; d_dk = DK_WR; end
      5'h0C: begin d_ncmd = 2'd1; d_c0 = 8'hE8; end
      5'h0D: begin d_ncmd = 2'd1; d_c0 = 8'(wmax - 11'd1); d_dk = DK_WR; d_wn = wmax; end
      5'h0E: begin d_ncmd = 2'd1; d_c0 = 8'hD0; end
      5'h0F: begin d_ncmd = 2'd1; d_c0 = 8'hB0; end
      5'h10: begin d_ncmd = 2'd1; d_c0 = 8'hD0; end
      5'h11: begin d_ncmd = 2'd1; d_c0 = 8'hC0; d_dk = DK_WR; end
      5'h12: begin d_ncmd = 2'd2; d_c0 = 8'h60; d_c1 = 8'h03; d_cfg = 1'b1; end
      5'h13: begin d_ncmd = 2'd2; d_c0 = 8'h60; d_c1 = 8'h01; end
      5'h14: begin d_ncmd = 2'd2; d_c0 = 8'h60; d_c1 = 8'hD0; end
      5'h15: begin d_ncmd = 2'd2; d_c0 = 8'h60; d_c1 = 8'h2F; end
      5'h16: begin d_ncmd = 2'd2; d_c0 = 8'hBC; d_c1 = 8'hD0; end
      default: ;
    endcase
  end

  // current list entry, taken from the working registers
  logic        cur_cmd, cur_rd, cur_dw, have, ready, d_have, d_ready, strobe_last, adv_ptr;
  logic [22:0] cur_addr;
  logic [15:0] cur_word;
  logic [7:0]  len_m1;

  assign cur_cmd     = (cidx < ncmd);
  assign cur_rd      = !cur_cmd && (dk == DK_RD);
  assign cur_dw      = !cur_cmd && (dk == DK_WR);
  assign have        = cur_cmd || ((dk != DK_NONE) && (wcnt != 11'd0));
  assign ready       = cur_cmd || (dk == DK_RD) || !wr_empty;
  assign d_have      = (d_ncmd != 2'd0) || (d_dk != DK_NONE);
  assign d_ready     = (d_ncmd != 2'd0) || (d_dk == DK_RD) || !wr_empty;
  assign cur_addr    = cur_cmd ? (use_cfg ? CFG_REG_ADDR : base) : wa;
  assign cur_word    = cur_cmd ? {8'h00, (cidx == 2'd0) ? c0 : c1} : wr_data;
  assign len_m1      = cur_rd ? 8'(RD_CYC - 1) : 8'(WE_CYC - 1);
  assign strobe_last = (cnt == len_m1);
  // the list pointer moves as the bus cycle enters RECOV
  assign adv_ptr     = (state == S_HOLD) || (state == S_STROBE && cur_rd && strobe_last);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and bus strobes; every output here falls to idle when state resets
  always_comb begin
    state_n = state; busy = 1'b1; seq_done = 1'b0; wr_rden = 1'b0;
    flash_ce_b = 1'b1; flash_oe_b = 1'b1; flash_we_b = 1'b1; flash_adv_b = 1'b1;
    flash_dq_oe = 1'b0; flash_a = 23'd0; flash_dq_o = 16'd0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (command != 5'd0) state_n = S_DECODE;
      end
      S_DECODE: state_n = !d_have ? S_DONE : (d_ready ? S_SETUP : S_NEXT);
      S_SETUP: begin
        flash_ce_b = 1'b0; flash_adv_b = 1'b0; flash_a = cur_addr;
        if (!cur_rd) begin flash_dq_oe = 1'b1; flash_dq_o = cur_word; end
        state_n = S_STROBE;
      end
      S_STROBE: begin
        flash_ce_b = 1'b0; flash_a = cur_addr;
        if (cur_rd) begin
          flash_oe_b = 1'b0;
          if (strobe_last) state_n = S_RECOV;
        end else begin
          flash_we_b = 1'b0; flash_dq_oe = 1'b1; flash_dq_o = cur_word;
          if (strobe_last) state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        flash_ce_b = 1'b0; flash_a = cur_addr; flash_dq_oe = 1'b1; flash_dq_o = cur_word;
        wr_rden = cur_dw;
        state_n = S_RECOV;
      end
      S_RECOV, S_NEXT: state_n = !have ? S_DONE : (ready ? S_SETUP : S_NEXT);
      S_DONE: begin
        seq_done = 1'b1;
        state_n = S_WAIT_NOOP;
      end
      S_WAIT_NOOP: begin
        busy = 1'b0;
        if (command == 5'd0) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Code latch, list registers, address pointers, read capture and error flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmd_q <= 5'd0; base <= 23'd0; wa <= 23'd0; ncmd <= 2'd0; cidx <= 2'd0;
      dk <= DK_NONE; c0 <= 8'd0; c1 <= 8'd0; use_cfg <= 1'b0; wcnt <= 11'd0;
      cnt <= 8'd0; rd_data <= 16'd0; rd_we <= 1'b0; cmd_err <= 1'b0;
    end else begin
      rd_we <= 1'b0;
      if (state == S_IDLE && command != 5'd0) cmd_q <= command;
      if (state == S_DECODE) begin
        ncmd <= d_ncmd; cidx <= 2'd0; c0 <= d_c0; c1 <= d_c1; use_cfg <= d_cfg;
        dk <= d_dk; wcnt <= d_wn; wa <= base;
        case (cmd_q)
          5'h17: base <= addr_in;
          5'h1C: cmd_err <= 1'b0;
          5'h18, 5'h1D, 5'h1E, 5'h1F: cmd_err <= 1'b1;
          default: ;
        endcase
      end
      if (state == S_SETUP) cnt <= 8'd0;
      if (state == S_STROBE) cnt <= cnt + 8'd1;
      if (state == S_STROBE && cur_rd && strobe_last) begin
        rd_data <= flash_dq_i;
        rd_we   <= 1'b1;
      end
      if (adv_ptr) begin
        if (cur_cmd) cidx <= cidx + 2'd1;
        else begin
          wcnt <= wcnt - 11'd1;
          wa   <= wa + 23'd1;
        end
      end
    end
  end

`ifdef BPI_TIMER_EN
  logic        timer_run;
  logic [31:0] timer_q;

  // Saturating elapsed-cycle timer controlled by codes 19 (start), 1A (stop), 1B (clear)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_run <= 1'b0;
      timer_q   <= 32'd0;
    end else begin
      if (timer_run && timer_q != 32'hFFFF_FFFF) timer_q <= timer_q + 32'd1;
      if (state == S_DECODE) begin
        case (cmd_q)
          5'h19: timer_run <= 1'b1;
          5'h1A: timer_run <= 1'b0;
          5'h1B: timer_q   <= 32'd0;
          default: ;
        endcase
      end
    end
  end
  assign timer = timer_q;
`else
  assign timer = 32'd0;
`endif

endmodule

// File: tb/tb_bpi_cmd_executor.sv
// tb/tb_bpi_cmd_executor.sv - scoreboard bench for bpi_cmd_executor
module tb_bpi_cmd_executor;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [4:0]  command = 5'd0;
  logic [22:0] addr_in = 23'd0;
  logic [10:0] n_words = 11'd1;
  logic [15:0] wr_data;
  logic        wr_empty;
  logic        wr_rden;
  logic [15:0] rd_data;
  logic        rd_we, seq_done, busy, cmd_err;
  logic [31:0] timer;
  logic [22:0] flash_a;
  logic [15:0] flash_dq_o;
  logic [15:0] flash_dq_i;
  logic        flash_dq_oe, flash_ce_b, flash_oe_b, flash_we_b, flash_adv_b;

  bpi_cmd_executor dut (
    .CLK(CLK), .RST(RST), .command(command), .addr_in(addr_in), .n_words(n_words),
    .wr_data(wr_data), .wr_empty(wr_empty), .wr_rden(wr_rden), .rd_data(rd_data),
    .rd_we(rd_we), .seq_done(seq_done), .busy(busy), .cmd_err(cmd_err), .timer(timer),
    .flash_a(flash_a), .flash_dq_o(flash_dq_o), .flash_dq_i(flash_dq_i),
    .flash_dq_oe(flash_dq_oe), .flash_ce_b(flash_ce_b), .flash_oe_b(flash_oe_b),
    .flash_we_b(flash_we_b), .flash_adv_b(flash_adv_b)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // flash read model
  always_comb begin
    case (flash_a)
      23'h7FFFFE: flash_dq_i = 16'h1111;
      23'h7FFFFF: flash_dq_i = 16'h2222;
      23'h000000: flash_dq_i = 16'h3333;
      default:    flash_dq_i = 16'hDEAD;
    endcase
  end

  // write FIFO model
  logic [15:0] fifo_mem [0:15];
  int fifo_wp = 0;
  int fifo_rp = 0;
  int rden_cnt = 0;
  assign wr_data  = fifo_mem[fifo_rp[3:0]];
  assign wr_empty = (fifo_rp == fifo_wp);
  always @(posedge CLK) begin
    if (!RST && wr_rden) begin
      fifo_rp  = fifo_rp + 1;
      rden_cnt = rden_cnt + 1;
    end
  end

  task automatic fifo_push(input logic [15:0] w);
    fifo_mem[fifo_wp[3:0]] = w;
    fifo_wp = fifo_wp + 1;
  endtask

  // scoreboard: kind 0 = write cycle, 1 = read word, 2 = seq_done
  typedef struct {
    int          kind;
    logic [22:0] addr;
    logic [15:0] data;
  } ev_t;
  ev_t exp_q[$];

  task automatic push(input int kind, input logic [22:0] a, input logic [15:0] d);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic sb_pop(input int kind, input logic [22:0] a, input logic [15:0] d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h expected none", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== a || e.data !== d) begin
        bad++;
        $display("FAIL sb_event: got kind=%0d addr=%0h data=%0h expected kind=%0d addr=%0h data=%0h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // monitor: turns bus activity into events and checks them against the queue
  logic        prev_we = 1'b1;
  int          we_len = 0;
  logic [22:0] rd_addr = 23'd0;
  always @(negedge CLK) begin
    if (RST) begin
      prev_we = 1'b1;
      we_len  = 0;
    end else begin
      if (!flash_we_b) we_len++;
      if (!flash_oe_b) rd_addr = flash_a;
      if (!prev_we && flash_we_b) begin
        sb_pop(0, flash_a, flash_dq_o);
        check("we_low_len", we_len, 3);
        we_len = 0;
      end
      if (rd_we) sb_pop(1, rd_addr, rd_data);
      if (seq_done) sb_pop(2, 23'd0, 16'd0);
      prev_we = flash_we_b;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      lat++;
      if (seq_done) return;
    end
    total++; bad++;
    $display("FAIL done_timeout: got no seq_done expected one within 400 cycles");
  endtask

  // hold the code after completion: must not retrigger; then release it
  task automatic end_cmd();
    logic idle_ok;
    idle_ok = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (busy || !flash_ce_b) idle_ok = 1'b0;
    end
    check("wait_noop_idle", {31'd0, idle_ok}, 1);
    command = 5'd0;
    tick(2);
  endtask

  task automatic run(input logic [4:0] code);
    int lat;
    command = code;
    wait_done(lat);
    end_cmd();
  endtask

  initial begin
    int lat;
    int r0;
    logic idle_ok;

    tick(3);
    check("rst_ce", {31'd0, flash_ce_b}, 1);
    check("rst_we", {31'd0, flash_we_b}, 1);
    check("rst_oe_adv", {30'd0, flash_oe_b, flash_adv_b}, 3);
    check("rst_dq_oe", {31'd0, flash_dq_oe}, 0);
    check("rst_flags", {27'd0, busy, cmd_err, seq_done, rd_we, wr_rden}, 0);
    check("rst_timer", timer, 0);
    check("rst_addr", {9'd0, flash_a}, 0);
    RST = 1'b0;
    tick(2);

    // Load_Address then Write_1
    addr_in = 23'h001234;
    push(2, 0, 0);
    run(5'h17);
    fifo_push(16'hABCD);
    push(0, 23'h001234, 16'hABCD);
    push(2, 0, 0);
    r0 = rden_cnt;
    command = 5'h01;
    wait_done(lat);
    check("write1_latency", lat, 8);
    end_cmd();
    check("write1_rden", rden_cnt - r0, 1);

    // Read_n across the address wrap, then Read_1 confirms base unchanged
    addr_in = 23'h7FFFFE;
    push(2, 0, 0);
    run(5'h17);
    n_words = 11'd3;
    push(1, 23'h7FFFFE, 16'h1111);
    push(1, 23'h7FFFFF, 16'h2222);
    push(1, 23'h000000, 16'h3333);
    push(2, 0, 0);
    run(5'h04);
    push(1, 23'h7FFFFE, 16'h1111);
    push(2, 0, 0);
    run(5'h02);

    // Buf_Prog_Wrt_n with an empty FIFO stall before the second word
    addr_in = 23'h000100;
    push(2, 0, 0);
    run(5'h17);
    n_words = 11'd2;
    fifo_push(16'hAAAA);
    push(0, 23'h000100, 16'h0001);
    push(0, 23'h000100, 16'hAAAA);
    push(0, 23'h000101, 16'hBBBB);
    push(2, 0, 0);
    r0 = rden_cnt;
    command = 5'h0D;
    for (int i = 0; i < 200 && rden_cnt == r0; i++) @(negedge CLK);
    check("bufprog_first_pop", rden_cnt - r0, 1);
    idle_ok = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      if (!flash_ce_b || flash_dq_oe) idle_ok = 1'b0;
    end
    check("stall_bus_idle", {31'd0, idle_ok}, 1);
    fifo_push(16'hBBBB);
    wait_done(lat);
    end_cmd();
    check("bufprog_rden", rden_cnt - r0, 2);

    // Set_Cnfg_Reg
    push(0, 23'h00F94F, 16'h0060);
    push(0, 23'h00F94F, 16'h0003);
    push(2, 0, 0);
    run(5'h12);

    // unassigned code, then clear status
    push(2, 0, 0);
    run(5'h1E);
    check("cmd_err_set", {31'd0, cmd_err}, 1);
    push(2, 0, 0);
    run(5'h1C);
    check("cmd_err_clr", {31'd0, cmd_err}, 0);

    // reset during the first write strobe of Block_Erase
    command = 5'h0A;
    for (int i = 0; i < 50 && flash_we_b; i++) @(negedge CLK);
    check("erase_strobe_seen", {31'd0, flash_we_b}, 0);
    RST = 1'b1;
    #1;
    check("midrst_strobes", {28'd0, flash_ce_b, flash_oe_b, flash_we_b, flash_adv_b}, 4'hF);
    check("midrst_dq_oe", {31'd0, flash_dq_oe}, 0);
    command = 5'd0;
    tick(2);
    RST = 1'b0;
    tick(5);
    push(0, 23'h000000, 16'h0020);
    push(0, 23'h000000, 16'h00D0);
    push(2, 0, 0);
    run(5'h0A);

    // timer start / stop
    push(2, 0, 0);
    command = 5'h19;
    wait_done(lat);
    command = 5'd0;
    tick(98);
    push(2, 0, 0);
    command = 5'h1A;
    wait_done(lat);
    end_cmd();
`ifdef BPI_TIMER_EN
    total++;
    if (timer < 32'd97 || timer > 32'd103) begin
      bad++;
      $display("FAIL timer_range: got %0d expected 97..103", timer);
    end
`else
    check("timer_disabled", timer, 0);
`endif

    tick(3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
